// File: rtl/pdi_block_formatter.sv
// Groups 32-bit message words into 128-bit Romulus blocks with 10*-len padding and emits one beat per word.
// Optional build macro PDI_FMT_MSGLEN_EN adds msg_len, a saturating byte count of the current message.
module pdi_block_formatter #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_start,
  input  logic        msg_dec,
  input  logic [31:0] bdi,
  input  logic [2:0]  bdi_size,
  input  logic        bdi_last,
  input  logic        bdi_valid,
  output logic        bdi_ready,
  input  logic        core_ready,
  output logic [31:0] pdi,
  output logic [3:0]  decrypt,
  output logic        se,
  output logic        blk_done,
  output logic        blk_pad,
  output logic [4:0]  blk_len,
  output logic        msg_done
`ifdef PDI_FMT_MSGLEN_EN
  ,
  output logic [31:0] msg_len
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD} state_t;

  state_t      state;
  logic [1:0]  word_cnt;
  logic [4:0]  byte_acc;
  logic        dec_q;

  logic        accept;
  logic        word_last;
  logic [2:0]  size_eff;
  logic [3:0]  lane_mask;
  logic [4:0]  new_len;
  logic [31:0] beat_word;

  assign bdi_ready = (state == LOAD) && core_ready;
  assign accept    = bdi_valid && bdi_ready;
  assign word_last = (word_cnt == 2'(BLOCK_WORDS - 1));

  // Byte j of the word sits in lane 3-j; a lane carries message data only if j < effective size.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size_eff  = 3'd4;
    lane_mask = 4'h0;
    beat_word = 32'h0;
    if (bdi_last)
      size_eff = (bdi_size > 3'd4) ? 3'd4 : bdi_size;
    for (int i = 0; i < 4; i++)
      lane_mask[i] = (3'(3 - i) < size_eff);
    new_len = byte_acc + {2'b00, size_eff};
    for (int i = 0; i < 4; i++)
      beat_word[8*i +: 8] = lane_mask[i] ? bdi[8*i +: 8] : 8'h00;
    // A short final word landing in word 3 carries the pad length byte itself.
    if (word_last && !new_len[4])
      beat_word[7:0] = {3'b000, new_len};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      word_cnt <= 2'd0;
      byte_acc <= 5'd0;
      dec_q    <= 1'b0;
      pdi      <= 32'h0;
      decrypt  <= 4'h0;
      se       <= 1'b0;
      blk_done <= 1'b0;
      blk_pad  <= 1'b0;
      blk_len  <= 5'd0;
      msg_done <= 1'b0;
    end else begin
      pdi      <= 32'h0;
      decrypt  <= 4'h0;
      se       <= 1'b0;
      blk_done <= 1'b0;
      blk_pad  <= 1'b0;
      blk_len  <= 5'd0;
      msg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (msg_start) begin
            dec_q    <= msg_dec;
            word_cnt <= 2'd0;
            byte_acc <= 5'd0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            se       <= 1'b1;
            pdi      <= beat_word;
            decrypt  <= {4{dec_q}} & lane_mask;
            word_cnt <= word_cnt + 2'd1;
            if (word_last) begin
              blk_done <= 1'b1;
              blk_len  <= new_len;
              byte_acc <= 5'd0;
              if (bdi_last) begin
                msg_done <= 1'b1;
                blk_pad  <= !new_len[4];
                state    <= IDLE;
              end
            end else begin
              byte_acc <= new_len;
              if (bdi_last)
                state <= PAD;
            end
          end
        end
        PAD: begin
          if (core_ready) begin
            se       <= 1'b1;
            word_cnt <= word_cnt + 2'd1;
            if (word_last) begin
              pdi      <= {27'h0, byte_acc};
              blk_done <= 1'b1;
              msg_done <= 1'b1;
              blk_pad  <= 1'b1;
              blk_len  <= byte_acc;
              byte_acc <= 5'd0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PDI_FMT_MSGLEN_EN
  logic [32:0] len_sum;
  assign len_sum = {1'b0, msg_len} + 33'(size_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      msg_len <= 32'h0;
    else if (state == IDLE && msg_start)
      msg_len <= 32'h0;
    else if (accept)
      msg_len <= len_sum[32] ? 32'hFFFF_FFFF : len_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_pdi_block_formatter.sv
// Scoreboard bench for pdi_block_formatter: directed messages push expected beats, a negedge monitor pops and compares.
module tb_pdi_block_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_start, msg_dec;
  logic [31:0] bdi;
  logic [2:0]  bdi_size;
  logic        bdi_last, bdi_valid, bdi_ready, core_ready;
  logic [31:0] pdi;
  logic [3:0]  decrypt;
  logic        se, blk_done, blk_pad, msg_done;
  logic [4:0]  blk_len;
`ifdef PDI_FMT_MSGLEN_EN
  logic [31:0] msg_len;
`endif

  always #5 clk = ~clk;

  pdi_block_formatter #(.BLOCK_WORDS(4)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .msg_dec(msg_dec),
    .bdi(bdi), .bdi_size(bdi_size), .bdi_last(bdi_last), .bdi_valid(bdi_valid),
    .bdi_ready(bdi_ready), .core_ready(core_ready), .pdi(pdi), .decrypt(decrypt),
    .se(se), .blk_done(blk_done), .blk_pad(blk_pad), .blk_len(blk_len), .msg_done(msg_done)
`ifdef PDI_FMT_MSGLEN_EN
    , .msg_len(msg_len)
`endif
  );

  typedef struct packed {
    logic [31:0] pdi;
    logic [3:0]  dec;
    logic        done;
    logic        pad;
    logic [4:0]  len;
    logic        mdone;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  cr_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_beat(input logic [31:0] p, input logic [3:0] d, input logic done,
                                      input logic pad, input logic [4:0] len, input logic md);
    beat_t b;
    b.pdi = p; b.dec = d; b.done = done; b.pad = pad; b.len = len; b.mdone = md;
    exp_q.push_back(b);
  endfunction

  // Monitor: compare every emitted beat against the scoreboard head; watch stall rules.
  always @(negedge clk) begin
    if (rst) begin
      if (!cr_prev) check("se_while_stalled", 32'(se), 32'h0);
      if (!core_ready) check("ready_while_stalled", 32'(bdi_ready), 32'h0);
      if (se) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got pdi %h expected no beat", pdi);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("pdi", pdi, e.pdi);
          check("decrypt", 32'(decrypt), 32'(e.dec));
          check("blk_done", 32'(blk_done), 32'(e.done));
          check("msg_done", 32'(msg_done), 32'(e.mdone));
          if (e.done) begin
            check("blk_pad", 32'(blk_pad), 32'(e.pad));
            check("blk_len", 32'(blk_len), 32'(e.len));
          end
        end
      end else if (blk_done || msg_done) begin
        n_vec++; n_err++;
        $display("FAIL stray_done: got blk_done %b msg_done %b expected 0 without se", blk_done, msg_done);
      end
    end
    cr_prev = core_ready;
  end

  task automatic start_msg(input logic dec);
    msg_start = 1'b1; msg_dec = dec;
    @(posedge clk); #1;
    msg_start = 1'b0; msg_dec = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] sz, input logic last);
    logic got;
    int   t;
    bdi = d; bdi_size = sz; bdi_last = last; bdi_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      got = bdi_ready;
      @(posedge clk); #1;
      t++;
    end while (!got && t < 200);
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no bdi_ready expected a handshake within 200 cycles");
    end
    bdi_valid = 1'b0; bdi_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pdi"}, pdi, 32'h0);
    check({tag, "_decrypt"}, 32'(decrypt), 32'h0);
    check({tag, "_se"}, 32'(se), 32'h0);
    check({tag, "_blk_done"}, 32'(blk_done), 32'h0);
    check({tag, "_blk_pad"}, 32'(blk_pad), 32'h0);
    check({tag, "_blk_len"}, 32'(blk_len), 32'h0);
    check({tag, "_msg_done"}, 32'(msg_done), 32'h0);
    check({tag, "_bdi_ready"}, 32'(bdi_ready), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within 500 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; msg_start = 1'b0; msg_dec = 1'b0; bdi = 32'h0; bdi_size = 3'd0;
    bdi_last = 1'b0; bdi_valid = 1'b0; core_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: full 16-byte encrypt block, no padding
    expect_beat(32'h00010203, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h04050607, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h08090A0B, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h0C0D0E0F, 4'h0, 1, 0, 5'd16, 1);
    start_msg(1'b0);
    send_word(32'h00010203, 3'd4, 1'b0);
    send_word(32'h04050607, 3'd4, 1'b0);
    send_word(32'h08090A0B, 3'd4, 1'b0);
    send_word(32'h0C0D0E0F, 3'd4, 1'b1);
    drain();

    // 2: decrypt, 6 bytes -> length byte 0x06 in word 3
    expect_beat(32'hAABBCCDD, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h11220000, 4'hC, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000006, 4'h0, 1, 1, 5'd6, 1);
    start_msg(1'b1);
    send_word(32'hAABBCCDD, 3'd4, 1'b0);
    send_word(32'h11223344, 3'd2, 1'b1);
    drain();

    // 3: empty message, decrypt flag must not leak into pad lanes
    for (int i = 0; i < 3; i++) expect_beat(32'h0, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h0, 4'h0, 1, 1, 5'd0, 1);
    start_msg(1'b1);
    send_word(32'h12345678, 3'd0, 1'b1);
    drain();

    // 4: 20-byte message with a 3-cycle core_ready drop mid-block
    expect_beat(32'hA0A1A2A3, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'hB0B1B2B3, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'hC0C1C2C3, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'hD0D1D2D3, 4'h0, 1, 0, 5'd16, 0);
    expect_beat(32'hE0E1E2E3, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000004, 4'h0, 1, 1, 5'd4, 1);
    start_msg(1'b0);
    fork
      begin
        send_word(32'hA0A1A2A3, 3'd4, 1'b0);
        send_word(32'hB0B1B2B3, 3'd4, 1'b0);
        send_word(32'hC0C1C2C3, 3'd4, 1'b0);
        send_word(32'hD0D1D2D3, 3'd4, 1'b0);
        send_word(32'hE0E1E2E3, 3'd4, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 core_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 core_ready = 1'b1;
      end
    join
    drain();

    // 5: reset after the 2nd beat discards the block; next message starts at word 0
    expect_beat(32'h01020304, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h05060708, 4'h0, 0, 0, 5'd0, 0);
    start_msg(1'b0);
    send_word(32'h01020304, 3'd4, 1'b0);
    send_word(32'h05060708, 3'd4, 1'b0);
    drain();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_beat(32'hDEADBE00, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000003, 4'h0, 1, 1, 5'd3, 1);
    start_msg(1'b0);
    send_word(32'hDEADBEEF, 3'd3, 1'b1);
    drain();

    // 6: short final word in word 3 carries length 15 in its low lane
    expect_beat(32'h11111111, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h22222222, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h33333333, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h4444440F, 4'hE, 1, 1, 5'd15, 1);
    start_msg(1'b1);
    send_word(32'h11111111, 3'd4, 1'b0);
    send_word(32'h22222222, 3'd4, 1'b0);
    send_word(32'h33333333, 3'd4, 1'b0);
    send_word(32'h44444499, 3'd3, 1'b1);
    drain();

    // 7: bdi_size 7 on a last beat clamps to 4
    expect_beat(32'hCAFEF00D, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000004, 4'h0, 1, 1, 5'd4, 1);
    start_msg(1'b0);
    send_word(32'hCAFEF00D, 3'd7, 1'b1);
    drain();

    // 8: non-last size ignored; size-0 last beat after two whole words pads from word 2
    expect_beat(32'h13579BDF, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h2468ACE0, 4'hF, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000008, 4'h0, 1, 1, 5'd8, 1);
    start_msg(1'b1);
    send_word(32'h13579BDF, 3'd1, 1'b0);
    send_word(32'h2468ACE0, 3'd4, 1'b0);
    send_word(32'hFFFFFFFF, 3'd0, 1'b1);
    drain();

`ifdef PDI_FMT_MSGLEN_EN
    // 9: 37-byte message length count, cleared by the next msg_start
    for (int i = 0; i < 9; i++)
      expect_beat({4{8'(i + 1)}}, 4'h0, (i == 3) || (i == 7), 0, 5'd16, 0);
    expect_beat(32'hAB000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000000, 4'h0, 0, 0, 5'd0, 0);
    expect_beat(32'h00000005, 4'h0, 1, 1, 5'd5, 1);
    start_msg(1'b0);
    for (int i = 0; i < 9; i++) send_word({4{8'(i + 1)}}, 3'd4, 1'b0);
    send_word(32'hAB123456, 3'd1, 1'b1);
    drain();
    check("msg_len_final", msg_len, 32'd37);
    start_msg(1'b0);
    check("msg_len_cleared", msg_len, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
